// File: rtl/sample_window_4.sv
// Samples din once every DIV enabled clocks into a 4-deep window and presents it as x4 (oldest)..x1 (newest)
// behind a valid/ready handshake; sliding (SLIDE=1) or block (SLIDE=0) mode. Optional macro SAMPLE_SYNC_EN adds a 2-flop din synchroniser.
module sample_window_4 #(
  parameter int DIV   = 4,
  parameter int SLIDE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic       ready,
  output logic       x4,
  output logic       x3,
  output logic       x2,
  output logic       x1,
  output logic       valid,
  output logic [2:0] fill,
  output logic       overrun
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [2:0] FILL_MAX = 3'd4;

  logic [7:0] div_cnt;
  logic       strobe;
  logic       din_s;
  logic [3:0] sreg;
  logic [3:0] sreg_next;
  logic [3:0] win;
  logic [2:0] fill_inc;
  logic       emit;

  function automatic logic [2:0] sat_fill(input logic [2:0] f);
    return (f >= FILL_MAX) ? FILL_MAX : f + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_fill(input logic [2:0] f);
    // Block mode restarts counting once a full window is handed off
    return (SLIDE == 0 && f == FILL_MAX) ? 3'd0 : f;
  endfunction

`ifdef SAMPLE_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Synchroniser stage boundary: din -> sync_p0 -> sync_p1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign din_s = sync_p1;
`else
  assign din_s = din;
`endif

  always_comb begin
    strobe    = en && (div_cnt == DIV_LAST);
    sreg_next = {sreg[2:0], din_s};
    fill_inc  = sat_fill(fill);
    emit      = strobe && (fill_inc == FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 8'd0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
    end
  end

  // Sample stage boundary: strobe shifts din_s into sreg and advances fill
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= 4'd0;
      fill <= 3'd0;
    end else if (strobe) begin
      sreg <= sreg_next;
      fill <= wrap_fill(fill_inc);
    end
  end

  // Output stage boundary: window load, handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      win     <= 4'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (emit) begin
      win   <= sreg_next;
      valid <= 1'b1;
      if (valid && !ready) overrun <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign {x4, x3, x2, x1} = win;

endmodule
